// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the 8-bit minifloat CPU. It decodes the IR opcode into memory, PC, IR, accumulator and bus controls.
// Optional build macro CPU_CTRL_STEP_EN adds a `step` input that resumes the sequencer from HALTED.
module cpu_controller #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef CPU_CTRL_STEP_EN
  input  logic       step,
`endif
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000, OP_SKZ = 3'b001, OP_ADD = 3'b010, OP_AND = 3'b011,
    OP_XOR = 3'b100, OP_LDA = 3'b101, OP_STO = 3'b110, OP_JMP = 3'b111
  } opcode_e;

  localparam logic [2:0] MEM_WAIT_C = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       run_q;
  logic       resume;

  logic is_hlt, is_skz, is_sto, is_jmp, is_alu;
  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

`ifdef CPU_CTRL_STEP_EN
  logic step_q;

  // Only a rising edge resumes, so holding step high gives exactly one resume.
  assign resume = step & ~step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end
`else
  assign resume = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INST_ADDR;
      wait_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      run_q   <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (run_q) begin
      unique case (state_q)
        INST_ADDR: state_d = INST_FETCH;
        INST_FETCH, OP_FETCH: begin
          if (wait_q == MEM_WAIT_C) begin
            wait_d  = '0;
            state_d = (state_q == INST_FETCH) ? INST_LOAD : ALU_OP;
          end else begin
            wait_d  = wait_q + 3'd1;
          end
        end
        INST_LOAD: state_d = IDLE;
        IDLE:      state_d = OP_ADDR;
        OP_ADDR:   state_d = is_hlt ? HALTED : OP_FETCH;
        ALU_OP:    state_d = STORE;
        STORE:     state_d = INST_ADDR;
        HALTED:    state_d = resume ? OP_FETCH : HALTED;
        default:   state_d = INST_ADDR;
      endcase
    end
  end

  // The run_q gate holds every output low for the first cycle after reset is released.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (run_q) begin
      unique case (state_q)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        OP_FETCH: rd = is_alu;
        ALU_OP: begin
          rd     = is_alu;
          inc_pc = is_skz & zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = is_alu;
          ld_ac  = is_alu;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        HALTED:  halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: MEM_WAIT=0 and MEM_WAIT=2 instances share stimulus.
// Output vectors are packed as {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}.
module tb_cpu_controller;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, LDA = 3'b101,
                         STO = 3'b110, JMP = 3'b111;

  localparam logic [8:0] P_Z   = 9'b000000000;
  localparam logic [8:0] P_IA  = 9'b100000000;
  localparam logic [8:0] P_IF  = 9'b110000000;
  localparam logic [8:0] P_IL  = 9'b111000000;
  localparam logic [8:0] P_OA  = 9'b000100000;
  localparam logic [8:0] P_OAH = 9'b000110000;
  localparam logic [8:0] P_HLT = 9'b000010000;
  localparam logic [8:0] P_ARD = 9'b010000000;
  localparam logic [8:0] P_AST = 9'b010000010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       zero;
  logic [2:0] opcode;
  logic       step;
  logic [8:0] o0, o2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  cpu_controller #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef CPU_CTRL_STEP_EN
    .step(step),
`endif
    .opcode(opcode), .zero(zero),
    .sel(o0[8]), .rd(o0[7]), .ld_ir(o0[6]), .inc_pc(o0[5]), .halt(o0[4]),
    .ld_pc(o0[3]), .data_e(o0[2]), .ld_ac(o0[1]), .wr(o0[0])
  );

  cpu_controller #(.MEM_WAIT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef CPU_CTRL_STEP_EN
    .step(step),
`endif
    .opcode(opcode), .zero(zero),
    .sel(o2[8]), .rd(o2[7]), .ld_ir(o2[6]), .inc_pc(o2[5]), .halt(o2[4]),
    .ld_pc(o2[3]), .data_e(o2[2]), .ld_ac(o2[1]), .wr(o2[0])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [0:7][8:0] exp = {P_IA, P_IF, P_IL, P_IL, P_OA, P_ARD, P_ARD, P_AST};
    rst_n = 1'b0; opcode = ADD; zero = 1'b0; step = 1'b0;
    repeat (3) tick();
    checks++;
    if ({o0, o2} !== 18'd0) begin
      errors++;
      $display("FAIL reset_hold got %b %b want all zero", o0, o2);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (o0 !== P_Z) begin
      errors++;
      $display("FAIL reset_first_cycle got %b want %b", o0, P_Z);
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c == 8) zero = 1'b1;
      checks++;
      if (o0 !== exp[c % 8]) begin
        errors++;
        $display("FAIL add_cycle%0d got %b want %b", c + 1, o0, exp[c % 8]);
      end
    end
  endtask

  task automatic test_sto();
    logic [0:7][8:0] exp = {P_IA, P_IF, P_IL, P_IL, P_OA, P_Z, 9'b000000100, 9'b000000101};
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin opcode = STO; zero = 1'b0; end
      checks++;
      if (o0 !== exp[c]) begin
        errors++;
        $display("FAIL sto_cycle%0d got %b want %b", c + 1, o0, exp[c]);
      end
    end
  endtask

  task automatic test_skz();
    logic [0:7][8:0] exp1 = {P_IA, P_IF, P_IL, P_IL, P_OA, P_Z, 9'b000100000, P_Z};
    logic [0:7][8:0] exp0 = {P_IA, P_IF, P_IL, P_IL, P_OA, P_Z, P_Z, P_Z};
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin opcode = SKZ; zero = 1'b1; end
      checks++;
      if (o0 !== exp1[c]) begin
        errors++;
        $display("FAIL skz_zero1_cycle%0d got %b want %b", c + 1, o0, exp1[c]);
      end
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) zero = 1'b0;
      checks++;
      if (o0 !== exp0[c]) begin
        errors++;
        $display("FAIL skz_zero0_cycle%0d got %b want %b", c + 1, o0, exp0[c]);
      end
    end
  endtask

  task automatic test_jmp();
    logic [0:7][8:0] exp = {P_IA, P_IF, P_IL, P_IL, P_OA, P_Z, 9'b000001000, 9'b000101000};
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin opcode = JMP; zero = 1'b1; end
      checks++;
      if (o0 !== exp[c]) begin
        errors++;
        $display("FAIL jmp_cycle%0d got %b want %b", c + 1, o0, exp[c]);
      end
    end
  endtask

  task automatic test_hlt();
    logic [0:7][8:0] exp = {P_IA, P_IF, P_IL, P_IL, P_OAH, P_HLT, P_HLT, P_HLT};
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin opcode = HLT; zero = 1'b0; end
      checks++;
      if (o0 !== exp[c]) begin
        errors++;
        $display("FAIL hlt_cycle%0d got %b want %b", c + 1, o0, exp[c]);
      end
    end
    for (int c = 0; c < 22; c++) begin
      tick();
      if (c == 10) opcode = ADD;
      checks++;
      if (o0 !== P_HLT) begin
        errors++;
        $display("FAIL hlt_hold%0d got %b want %b", c, o0, P_HLT);
      end
    end
`ifdef CPU_CTRL_STEP_EN
    opcode = HLT;
    step = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (o0 !== P_Z) begin
        errors++;
        $display("FAIL step_noop%0d got %b want %b", c, o0, P_Z);
      end
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (o0 !== exp[c]) begin
        errors++;
        $display("FAIL step_refetch_cycle%0d got %b want %b", c + 1, o0, exp[c]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (o0 !== P_HLT) begin
        errors++;
        $display("FAIL step_held_one_resume%0d got %b want %b", c, o0, P_HLT);
      end
    end
    step = 1'b0;
`endif
  endtask

  task automatic test_mem_wait();
    logic [0:11][8:0] exp = {P_IA, P_IF, P_IF, P_IF, P_IL, P_IL, P_OA,
                             P_ARD, P_ARD, P_ARD, P_ARD, P_AST};
    rst_n = 1'b0; opcode = LDA; zero = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (o2 !== P_Z) begin
      errors++;
      $display("FAIL wait_first_cycle got %b want %b", o2, P_Z);
    end
    for (int c = 0; c < 23; c++) begin
      tick();
      checks++;
      if (o2 !== exp[c % 12]) begin
        errors++;
        $display("FAIL wait_cycle%0d got %b want %b", c + 1, o2, exp[c % 12]);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o2 !== P_Z) begin
      errors++;
      $display("FAIL abort_immediate got %b want %b", o2, P_Z);
    end
    tick();
    checks++;
    if (o2 !== P_Z) begin
      errors++;
      $display("FAIL abort_no_ld_ac got %b want %b", o2, P_Z);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (o2 !== P_IA) begin
      errors++;
      $display("FAIL abort_restart got %b want %b", o2, P_IA);
    end
    tick();
    checks++;
    if (o2 !== P_IF) begin
      errors++;
      $display("FAIL abort_refetch got %b want %b", o2, P_IF);
    end
  endtask

  initial begin
    test_reset();
    test_sto();
    test_skz();
    test_jmp();
    test_hlt();
    test_mem_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
